lstm_cell_seq: RTL

- Sequencer wrapped around the element-wise PE datapath.
- Accepts streamed activated gate quadruples (i, f, g, o), one hidden unit per handshake, from the activation stage.
- Supplies c_prev from an internal cell-state buffer and writes the new c back to that buffer.
- Registers c and h toward the h-buffer/next-timestep consumer through a valid/ready output port, with end-of-timestep marking.

---
 rtl/lstm_pkg.sv | 19 +
 rtl/lstm_pe.sv | 50 +++++
 rtl/lstm_cell_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared constants and FSM state type for the LSTM cell sequencer
package lstm_pkg;

  localparam int LSTM_WIDTH       = 12;
  localparam int LSTM_FRAC_BITS   = 8;
  localparam int LSTM_HIDDEN_SIZE = 16;

  function automatic int fx_one(input int frac_bits);
    return 1 << frac_bits;
  endfunction

  localparam int LSTM_ONE = fx_one(LSTM_FRAC_BITS);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } seq_state_e;

endpackage

// File: rtl/lstm_pe.sv
// rtl/lstm_pe.sv - combinational LSTM element-wise datapath: c = f*c_prev + i*g, h = o*tanh(c)
// tanh is the hard-clamp form; every product and sum saturates to WIDTH bits.
module lstm_pe
  import lstm_pkg::*;
#(
  parameter int WIDTH     = LSTM_WIDTH,
  parameter int FRAC_BITS = LSTM_FRAC_BITS
) (
  input  logic [WIDTH-1:0] i_i,
  input  logic [WIDTH-1:0] f_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] o_i,
  input  logic [WIDTH-1:0] c_prev_i,
  output logic [WIDTH-1:0] c_o,
  output logic [WIDTH-1:0] h_o
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] MAX_W = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_W = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] ONE_W = PW'(fx_one(FRAC_BITS));

  function automatic logic [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAX_W) return MAX_W[WIDTH-1:0];
    if (v < MIN_W) return MIN_W[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  logic signed [PW-1:0] fc_p, ig_p, sum_w, tc_w, oh_p;
  logic [WIDTH-1:0] fc_s, ig_s, c_s;

  always_comb begin
    fc_p  = PW'($signed(f_i)) * PW'($signed(c_prev_i));
    ig_p  = PW'($signed(i_i)) * PW'($signed(g_i));
    fc_s  = sat(fc_p >>> FRAC_BITS);
    ig_s  = sat(ig_p >>> FRAC_BITS);
    sum_w = PW'($signed(fc_s)) + PW'($signed(ig_s));
    c_s   = sat(sum_w);
    tc_w  = PW'($signed(c_s));
    if (tc_w > ONE_W) begin
      tc_w = ONE_W;
    end else if (tc_w < -ONE_W) begin
      tc_w = -ONE_W;
    end
    oh_p = PW'($signed(o_i)) * tc_w;
    c_o  = c_s;
    h_o  = sat(oh_p >>> FRAC_BITS);
  end

endmodule

// File: rtl/lstm_cell_seq.sv
// rtl/lstm_cell_seq.sv - LSTM cell sequencer: streams gate quadruples through the PE,
// keeps per-unit cell state in an inline buffer and registers c/h toward the consumer.
module lstm_cell_seq
  import lstm_pkg::*;
#(
  parameter int WIDTH       = LSTM_WIDTH,
  parameter int FRAC_BITS   = LSTM_FRAC_BITS,
  parameter int HIDDEN_SIZE = LSTM_HIDDEN_SIZE,
  parameter int IDX_W       = $clog2(HIDDEN_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_req,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] in_f,
  input  logic [WIDTH-1:0] in_g,
  input  logic [WIDTH-1:0] in_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_h,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HIDDEN_SIZE - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic [WIDTH-1:0] out_h_q, out_h_d;
  logic [WIDTH-1:0] cbuf_q [HIDDEN_SIZE];
  logic [WIDTH-1:0] pe_c, pe_h;
  logic             accept;

  lstm_pe #(
    .WIDTH    (WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_pe (
    .i_i     (in_i),
    .f_i     (in_f),
    .g_i     (in_g),
    .o_i     (in_o),
    .c_prev_i(cbuf_q[idx_q]),
    .c_o     (pe_c),
    .h_o     (pe_h)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_c_d     = out_c_q;
    out_h_d     = out_h_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        idx_d     = '0;
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      ST_RUN: begin
        in_ready = !clear_req && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          idx_d     = '0;
        end else if (accept) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    // A pending word is independent of the FSM, so it drains even while clearing.
    if (accept) begin
      out_valid_d = 1'b1;
      out_c_d     = pe_c;
      out_h_d     = pe_h;
      out_idx_d   = idx_q;
      out_last_d  = (idx_q == LAST_IDX);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_c_q     <= '0;
      out_h_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_c_q     <= out_c_d;
      out_h_q     <= out_h_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      cbuf_q[clr_cnt_q] <= '0;
    end else if (accept) begin
      cbuf_q[idx_q] <= pe_c;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_c     = out_c_q;
  assign out_h     = out_h_q;

endmodule
